pwm_seq_ctrl: RTL and testbench

- Command sequencer for the PWM motor datapath.
- Fetches 16-bit motor command words from a synchronous block memory with one-cycle read latency.
- Ramps speed toward each command's target at a fixed rate per control tick, then holds the command for a programmed number of ticks.
- Drives the PWM data word; replaces the free-running program counter with a rate-limited, direction-safe, stoppable sequence.

---
 rtl/pwm_seq_ctrl_if.sv | 21 ++
 rtl/pwm_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pwm_seq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_seq_ctrl_if.sv
// Command-memory read bus between the PWM sequencer and its block RAM.
// Read data is valid the cycle after mem_en.
interface pwm_seq_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [15:0]       mem_data;

  modport master (
    output mem_addr,
    output mem_en,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_en,
    output mem_data
  );
endinterface

// File: rtl/pwm_seq_ctrl.sv
// PWM command sequencer: fetches command words, ramps speed per tick,
// holds, loops on last-flagged entries and performs controlled stops.
module pwm_seq_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int STEP       = 4,
  parameter int START_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  pwm_seq_ctrl_if.master mem,
  output logic [15:0] pwm_data,
  output logic        busy,
  output logic        loop_pulse,
  output logic        done
);

  localparam logic [7:0] STEP_B = 8'(STEP);
  localparam logic [ADDR_W-1:0] START_A =
    ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ONE_A =
    ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LATCH,
    S_RAMP,
    S_HOLD,
    S_STOP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              en_q;
  logic [7:0]        speed;
  logic              dir;
  logic [7:0]        tgt_speed;
  logic              tgt_dir;
  logic              tgt_last;
  logic [5:0]        tgt_hold;
  logic [5:0]        hold_cnt;

  logic [7:0] dn_lim;
  logic [7:0] gap;
  logic [7:0] gap_lim;
  logic       at_tgt;
  logic       busy_st;

  assign dn_lim  = (speed > STEP_B) ? STEP_B : speed;
  assign gap     = (speed < tgt_speed) ?
                   tgt_speed - speed :
                   speed - tgt_speed;
  assign gap_lim = (gap > STEP_B) ? STEP_B : gap;
  assign at_tgt  = (speed == tgt_speed) &&
                   (dir == tgt_dir);
  assign busy_st = (state != S_IDLE) &&
                   (state != S_STOP);

  assign mem.mem_addr = addr_q;
  assign mem.mem_en   = en_q;
  assign pwm_data     = {dir, 7'b0, speed};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= START_A;
      en_q       <= 1'b0;
      speed      <= 8'd0;
      dir        <= 1'b0;
      tgt_speed  <= 8'd0;
      tgt_dir    <= 1'b0;
      tgt_last   <= 1'b0;
      tgt_hold   <= 6'd1;
      hold_cnt   <= 6'd1;
      busy       <= 1'b0;
      loop_pulse <= 1'b0;
      done       <= 1'b0;
    end else begin
      loop_pulse <= 1'b0;
      done       <= 1'b0;
      if (stop && busy_st) begin
        // any fetch in flight is simply never latched
        state <= S_STOP;
        en_q  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state <= S_FETCH;
              en_q  <= 1'b1;
              busy  <= 1'b1;
            end
          end
          S_FETCH: begin
            en_q  <= 1'b0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            state <= S_LATCH;
          end
          S_LATCH: begin
            tgt_dir   <= mem.mem_data[15];
            tgt_last  <= mem.mem_data[14];
            tgt_hold  <= (mem.mem_data[13:8] == 6'd0) ?
                         6'd1 : mem.mem_data[13:8];
            tgt_speed <= mem.mem_data[7:0];
            state     <= S_RAMP;
          end
          S_RAMP: begin
            if (at_tgt) begin
              hold_cnt <= tgt_hold;
              state    <= S_HOLD;
            end else if (tick) begin
              if (dir != tgt_dir) begin
                // reverse only once the motor is at rest
                if (speed != 8'd0)
                  speed <= speed - dn_lim;
                else
                  dir <= tgt_dir;
              end else if (speed < tgt_speed) begin
                speed <= speed + gap_lim;
              end else begin
                speed <= speed - gap_lim;
              end
            end
          end
          S_HOLD: begin
            if (tick) begin
              if (hold_cnt == 6'd1) begin
                if (tgt_last) begin
                  addr_q     <= START_A;
                  loop_pulse <= 1'b1;
                end else begin
                  addr_q <= addr_q + ONE_A;
                end
                en_q  <= 1'b1;
                state <= S_FETCH;
              end else begin
                hold_cnt <= hold_cnt - 6'd1;
              end
            end
          end
          S_STOP: begin
            if (speed == 8'd0) begin
              done   <= 1'b1;
              addr_q <= START_A;
              busy   <= 1'b0;
              state  <= S_IDLE;
            end else if (tick) begin
              speed <= speed - dn_lim;
            end
          end
          default: begin
            state <= S_IDLE;
            en_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Directed bench for pwm_seq_ctrl: vector table of tick/stop/restart
// steps with hand-computed outputs, plus timing and reset sequences.
module tb_pwm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] pwm_data;
  logic        busy;
  logic        loop_pulse;
  logic        done;

  logic [15:0] mem [0:255];

  int n_run  = 0;
  int n_fail = 0;
  int lp_cnt = 0;
  int dn_cnt = 0;
  int en_cnt = 0;

  pwm_seq_ctrl_if #(.ADDR_W(8)) bus ();

  pwm_seq_ctrl #(
    .ADDR_W(8),
    .STEP(4),
    .START_ADDR(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .start(start),
    .stop(stop),
    .mem(bus),
    .pwm_data(pwm_data),
    .busy(busy),
    .loop_pulse(loop_pulse),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.mem_en)
      bus.mem_data <= mem[bus.mem_addr];

  always @(posedge clk) begin
    if (loop_pulse) lp_cnt++;
    if (done) dn_cnt++;
    if (bus.mem_en) en_cnt++;
  end

  localparam int RS = 0;
  localparam int TK = 1;
  localparam int SP = 2;

  typedef struct {
    int          mode;
    logic [15:0] m0;
    logic [15:0] m1;
    logic [15:0] pwm;
    logic        busy;
    int          lp;
    int          dn;
    logic [7:0]  addr;
  } vec_t;

  vec_t tbl[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (8) cyc();
  endtask

  task automatic chk(string nm, int idx,
                     logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic add(int mode, logic [15:0] pwm,
                     logic b, int lp, int dn,
                     logic [7:0] addr,
                     logic [15:0] m0 = 16'h0,
                     logic [15:0] m1 = 16'h0);
    vec_t v;
    v.mode = mode;
    v.m0   = m0;
    v.m1   = m1;
    v.pwm  = pwm;
    v.busy = b;
    v.lp   = lp;
    v.dn   = dn;
    v.addr = addr;
    tbl.push_back(v);
  endtask

  task automatic tk(logic [15:0] pwm, logic [7:0] addr,
                    int lp = 0);
    add(TK, pwm, 1'b1, lp, 0, addr);
  endtask

  task automatic build();
    // A: ramp 0->32, hold 3, loop
    add(RS, 16'h0, 1'b1, 0, 0, 8'd0, 16'h4320);
    for (int s = 4; s <= 32; s += 4)
      tk(16'(s), 8'd0);
    tk(16'h0020, 8'd0);
    tk(16'h0020, 8'd0);
    tk(16'h0020, 8'd0, 1);
    tk(16'h0020, 8'd0);
    // B: direction reversal both ways
    add(RS, 16'h0, 1'b1, 0, 0, 8'd0, 16'h0110, 16'hC110);
    for (int s = 4; s <= 16; s += 4)
      tk(16'(s), 8'd0);
    tk(16'h0010, 8'd1);
    for (int s = 12; s >= 0; s -= 4)
      tk(16'(s), 8'd1);
    tk(16'h8000, 8'd1);
    for (int s = 4; s <= 16; s += 4)
      tk(16'h8000 | 16'(s), 8'd1);
    tk(16'h8010, 8'd0, 1);
    for (int s = 12; s >= 0; s -= 4)
      tk(16'h8000 | 16'(s), 8'd0);
    tk(16'h0000, 8'd0);
    tk(16'h0004, 8'd0);
    // C: last step clipped, hold 0 acts as 1
    add(RS, 16'h0, 1'b1, 0, 0, 8'd0, 16'h400A);
    tk(16'h0004, 8'd0);
    tk(16'h0008, 8'd0);
    tk(16'h000A, 8'd0);
    tk(16'h000A, 8'd0, 1);
    tk(16'h000A, 8'd0, 1);
    // D: stop mid-ramp at 12
    add(RS, 16'h0, 1'b1, 0, 0, 8'd0, 16'h4320);
    tk(16'h0004, 8'd0);
    tk(16'h0008, 8'd0);
    tk(16'h000C, 8'd0);
    add(SP, 16'h000C, 1'b1, 0, 0, 8'd0);
    tk(16'h0008, 8'd0);
    tk(16'h0004, 8'd0);
    add(TK, 16'h0000, 1'b0, 0, 1, 8'd0);
    add(TK, 16'h0000, 1'b0, 0, 0, 8'd0);
    add(SP, 16'h0000, 1'b0, 0, 0, 8'd0);
    // E: stop at entry 1 restores the start address
    add(RS, 16'h0, 1'b1, 0, 0, 8'd0, 16'h0110, 16'hC110);
    for (int s = 4; s <= 16; s += 4)
      tk(16'(s), 8'd0);
    tk(16'h0010, 8'd1);
    tk(16'h000C, 8'd1);
    add(SP, 16'h000C, 1'b1, 0, 0, 8'd1);
    tk(16'h0008, 8'd1);
    tk(16'h0004, 8'd1);
    add(TK, 16'h0000, 1'b0, 0, 1, 8'd0);
  endtask

  task automatic run_vec(int i, vec_t v);
    int lp0;
    int dn0;
    if (v.mode == RS) begin
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      mem[0] = v.m0;
      mem[1] = v.m1;
      cyc();
    end
    lp0 = lp_cnt;
    dn0 = dn_cnt;
    unique case (v.mode)
      RS: start = 1'b1;
      TK: tick = 1'b1;
      default: stop = 1'b1;
    endcase
    cyc();
    start = 1'b0;
    tick  = 1'b0;
    stop  = 1'b0;
    settle();
    chk("pwm", i, 32'(pwm_data), 32'(v.pwm));
    chk("busy", i, 32'(busy), 32'(v.busy));
    chk("loop", i, lp_cnt - lp0, v.lp);
    chk("done", i, dn_cnt - dn0, v.dn);
    chk("addr", i, 32'(bus.mem_addr), 32'(v.addr));
  endtask

  initial begin
    int e0;
    int d0;
    for (int a = 0; a < 256; a++)
      mem[a] = 16'h0;

    // reset held with ticks toggling
    for (int i = 0; i < 6; i++) begin
      tick = ~tick;
      cyc();
      chk("rst_hold", i,
          {pwm_data, 13'b0, busy, bus.mem_en, 1'b0,
           |bus.mem_addr},
          32'h0);
    end
    rst = 1'b0;
    e0 = en_cnt;
    for (int i = 0; i < 6; i++) begin
      tick = ~tick;
      cyc();
    end
    tick = 1'b0;
    chk("no_start_en", 0, en_cnt - e0, 0);
    chk("no_start_pwm", 0, 32'(pwm_data), 32'h0);

    // fetch handshake and fetch-to-latch latency
    mem[0] = 16'h4320;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("fetch_en", 0,
        {busy, bus.mem_en, bus.mem_addr}, {2'b11, 8'd0});
    tick = 1'b1;
    cyc();
    chk("fetch_1cyc", 0, 32'(bus.mem_en), 32'h0);
    tick = 1'b0;
    cyc();
    tick = 1'b1;
    cyc();
    cyc();
    tick = 1'b0;
    chk("latch_lat", 0, 32'(pwm_data), 32'h0004);
    for (int i = 0; i < 7; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      settle();
    end
    chk("ramp_32", 0, 32'(pwm_data), 32'h0020);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    settle();

    // asynchronous reset mid-hold
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst", 0,
        {pwm_data, 14'b0, busy, bus.mem_en},
        32'h0);
    cyc();
    rst = 1'b0;
    e0 = en_cnt;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
    chk("post_rst_idle", 0,
        {en_cnt - e0}, 32'h0);
    chk("post_rst_pwm", 0, 32'(pwm_data), 32'h0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart", 0,
        {bus.mem_en, bus.mem_addr}, {1'b1, 8'd0});
    settle();

    // start+stop: start wins in idle, stop wins when busy
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_wins", 0, 32'(busy), 32'h1);
    settle();
    e0 = en_cnt;
    d0 = dn_cnt;
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    settle();
    chk("stop_wins", 0,
        {busy, 7'b0, 8'(dn_cnt - d0), 8'(en_cnt - e0)},
        {1'b0, 7'b0, 8'd1, 8'd0});

    build();
    foreach (tbl[i])
      run_vec(i, tbl[i]);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
